// File: rtl/rnn_pkg.sv
// rnn_pkg: widths, bank-select constants and arbiter FSM states shared by
// the RNN memory subsystem.
//   RNN_AW / RNN_DW / RNN_SW : memory address, data and bank-select widths
//   MSEL_*                   : bank-select encodings (IDLE parks the bus,
//                              RESULT is the only writable bank)
//   arb_state_e              : ARB (round-robin search) / HOLD (burst lock)
package rnn_pkg;

    localparam int unsigned RNN_AW = 17;
    localparam int unsigned RNN_DW = 20;
    localparam int unsigned RNN_SW = 3;

    localparam logic [RNN_SW-1:0] MSEL_BANK0  = 3'b000;
    localparam logic [RNN_SW-1:0] MSEL_BANK1  = 3'b001;
    localparam logic [RNN_SW-1:0] MSEL_BANK2  = 3'b010;
    localparam logic [RNN_SW-1:0] MSEL_BANK3  = 3'b011;
    localparam logic [RNN_SW-1:0] MSEL_IDLE   = 3'b100;
    localparam logic [RNN_SW-1:0] MSEL_RESULT = 3'b101;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rnn_mem_arbiter_if.sv
// rnn_mem_arbiter_if: requester-side handshake plus memory-pin bundle of the
// RNN memory arbiter.
//   req/lock/req_sel/req_addr/req_wdata : per-requester request, packed slices
//   gnt/rvalid/rdata                     : grant and steered read response
//   mce/maddr/msel/mdata_w/mdata_r       : single shared memory port
// Modports: slave = arbiter, master = requesters + memory.
interface rnn_mem_arbiter_if
    import rnn_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = RNN_AW,
    parameter int unsigned DW   = RNN_DW,
    parameter int unsigned SW   = RNN_SW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*SW-1:0] req_sel;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mce;
    logic [AW-1:0]      maddr;
    logic [SW-1:0]      msel;
    logic [DW-1:0]      mdata_w;
    logic [DW-1:0]      mdata_r;

    modport slave (
        input  req, lock, req_sel, req_addr, req_wdata, mdata_r,
        output gnt, rvalid, rdata, mce, maddr, msel, mdata_w
    );

    modport master (
        output req, lock, req_sel, req_addr, req_wdata, mdata_r,
        input  gnt, rvalid, rdata, mce, maddr, msel, mdata_w
    );
endinterface

// File: rtl/rnn_rr_pick.sv
// rnn_rr_pick: combinational round-robin one-hot picker.
//   req_i : request vector
//   ptr_i : index searched first; search proceeds upward and wraps
//   gnt_o : one-hot grant to the first requester found (zero if none)
module rnn_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rnn_mem_arbiter.sv
// rnn_mem_arbiter: shares the single RNN memory port between NREQ requesters
// (0 = compute engine, then host weight loader, hidden-state dump reader).
// Round-robin with optional burst lock; read responses are steered back to
// their issuer after RD_LAT cycles of memory latency, in issue order.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rnn_mem_arbiter_if.slave (requester handshake + memory pins)
// Build option: RNN_ARB_QOS_EN gives requester 0 strict priority while in
// ARB; the pointer then only advances on grants to requesters 1..NREQ-1.
module rnn_mem_arbiter
    import rnn_pkg::*;
#(
    parameter int unsigned   NREQ   = 3,
    parameter int unsigned   AW     = RNN_AW,
    parameter int unsigned   DW     = RNN_DW,
    parameter int unsigned   SW     = RNN_SW,
    parameter logic [SW-1:0] WR_SEL = SW'(MSEL_RESULT),
    parameter int unsigned   RD_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    rnn_mem_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;

    logic [NREQ-1:0] pick_gnt;
    logic [NREQ-1:0] gnt_c;
    logic            xfer;
    logic [PW-1:0]   win;
    logic [SW-1:0]   sel_w;
    logic [AW-1:0]   addr_w;
    logic [DW-1:0]   wdata_w;

    logic            mce_q;
    logic [AW-1:0]   maddr_q;
    logic [SW-1:0]   msel_q;
    logic [DW-1:0]   mdata_w_q;

    // Stage 0 is aligned with the registered memory command; stage RD_LAT
    // lines up with mdata_r.
    logic [RD_LAT:0]         pv_q;
    logic [RD_LAT:0][PW-1:0] pid_q;
    logic [NREQ-1:0]         rvalid_c;

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rnn_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    always_comb begin
        gnt_c = '0;
        if (state_q == HOLD) begin
            gnt_c[owner_q] = bus.req[owner_q];
        end else begin
`ifdef RNN_ARB_QOS_EN
            if (bus.req[0]) begin
                gnt_c[0] = 1'b1;
            end else begin
                gnt_c = pick_gnt;
            end
`else
            gnt_c = pick_gnt;
`endif
        end
    end

    // gnt is already qualified by req, so any grant bit is a transfer.
    assign xfer = |gnt_c;

    always_comb begin
        win     = '0;
        sel_w   = '0;
        addr_w  = '0;
        wdata_w = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_c[k]) begin
                win     = PW'(k);
                sel_w   = bus.req_sel[k*SW +: SW];
                addr_w  = bus.req_addr[k*AW +: AW];
                wdata_w = bus.req_wdata[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ARB: begin
                if (xfer) begin
                    if (bus.lock[win]) begin
                        state_d = HOLD;
                        owner_d = win;
                    end else begin
`ifdef RNN_ARB_QOS_EN
                        if (win != '0) begin
                            ptr_d = adv(win);
                        end
`else
                        ptr_d = adv(win);
`endif
                    end
                end
            end
            HOLD: begin
                // Leave on the last locked transfer or when the owner drops req.
                if (!bus.req[owner_q] || !bus.lock[owner_q]) begin
                    state_d = ARB;
`ifdef RNN_ARB_QOS_EN
                    if (owner_q != '0) begin
                        ptr_d = adv(owner_q);
                    end
`else
                    ptr_d = adv(owner_q);
`endif
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mce_q     <= 1'b0;
            maddr_q   <= '0;
            msel_q    <= SW'(MSEL_IDLE);
            mdata_w_q <= '0;
        end else if (xfer) begin
            mce_q     <= 1'b1;
            maddr_q   <= addr_w;
            msel_q    <= sel_w;
            mdata_w_q <= wdata_w;
        end else begin
            mce_q  <= 1'b0;
            msel_q <= SW'(MSEL_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q  <= '0;
            pid_q <= '0;
        end else begin
            pv_q[0]  <= xfer && (sel_w != WR_SEL);
            pid_q[0] <= win;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                pv_q[k]  <= pv_q[k-1];
                pid_q[k] <= pid_q[k-1];
            end
        end
    end

    always_comb begin
        rvalid_c = '0;
        if (pv_q[RD_LAT]) begin
            rvalid_c[pid_q[RD_LAT]] = 1'b1;
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.rvalid  = rvalid_c;
    assign bus.rdata   = bus.mdata_r;
    assign bus.mce     = mce_q;
    assign bus.maddr   = maddr_q;
    assign bus.msel    = msel_q;
    assign bus.mdata_w = mdata_w_q;
endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// tb_rnn_mem_arbiter: table-driven bench for rnn_mem_arbiter with a read
// response scoreboard and a behavioural single-port memory (RD_LAT = 1).
module tb_rnn_mem_arbiter;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  lock;
        logic [2:0]  sel;
        logic [16:0] addr;
        logic [19:0] wdata;
        logic [2:0]  gnt;
    } vec_t;

    typedef struct {
        int unsigned due;
        int unsigned id;
        logic [19:0] data;
    } sb_t;

    logic clk;
    logic reset;

    rnn_mem_arbiter_if #(.NREQ(3), .AW(17), .DW(20), .SW(3)) bus ();

    rnn_mem_arbiter #(
        .NREQ   (3),
        .AW     (17),
        .DW     (20),
        .SW     (3),
        .WR_SEL (3'b101),
        .RD_LAT (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: writes land in the result bank store, reads of
    // unwritten locations return {msel, maddr}.
    logic [19:0] wmem [0:4095];
    logic        wv   [0:4095];

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4096; k++) wv[k] <= 1'b0;
        end else if (bus.mce) begin
            if (bus.msel == 3'b101) begin
                wmem[bus.maddr[11:0]] <= bus.mdata_w;
                wv[bus.maddr[11:0]]   <= 1'b1;
            end else begin
                bus.mdata_r <= wv[bus.maddr[11:0]] ? wmem[bus.maddr[11:0]]
                                                   : {bus.msel, bus.maddr};
            end
        end
    end

    int          tests;
    int          failed;
    int unsigned cyc;
    sb_t         sbq[$];
    vec_t        vecs[$];
    logic [19:0] sh_mem [0:4095];
    logic        sh_v   [0:4095];

    logic        e_mce;
    logic [16:0] e_maddr;
    logic [2:0]  e_msel;
    logic [19:0] e_mdw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [2:0] lock,
                                input logic [2:0] sel, input logic [16:0] addr,
                                input logic [19:0] wdata, input logic [2:0] gnt);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.sel = sel;
        v.addr = addr; v.wdata = wdata; v.gnt = gnt;
        return v;
    endfunction

    task automatic do_row(input vec_t v);
        logic [2:0]  exp_rv;
        int unsigned id;
        logic [16:0] ea;
        logic [19:0] ew;
        // Registered memory command and steered response from the previous cycle.
        chk("mce", 32'(bus.mce), 32'(e_mce));
        chk("maddr", 32'(bus.maddr), 32'(e_maddr));
        chk("msel", 32'(bus.msel), 32'(e_msel));
        chk("mdata_w", 32'(bus.mdata_w), 32'(e_mdw));
        exp_rv = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) exp_rv = 3'(1 << sbq[0].id);
        chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
        if (exp_rv != '0) begin
            chk("rdata", 32'(bus.rdata), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end
        reset         = v.rst;
        bus.req       = v.req;
        bus.lock      = v.lock;
        bus.req_sel   = {3{v.sel}};
        bus.req_addr  = {v.addr + 17'd2, v.addr + 17'd1, v.addr};
        bus.req_wdata = {v.wdata + 20'd2, v.wdata + 20'd1, v.wdata};
        #3;
        chk("gnt", 32'(bus.gnt), 32'(v.gnt));
        if (v.rst) begin
            e_mce = 1'b0; e_maddr = '0; e_msel = 3'b100; e_mdw = '0;
            sbq.delete();
            for (int k = 0; k < 4096; k++) sh_v[k] = 1'b0;
        end else if ((v.req & v.gnt) != 3'b000) begin
            id = 0;
            for (int i = 0; i < 3; i++) if (v.req[i] & v.gnt[i]) id = i;
            ea = v.addr + 17'(id);
            ew = v.wdata + 20'(id);
            e_mce = 1'b1; e_maddr = ea; e_msel = v.sel; e_mdw = ew;
            if (v.sel == 3'b101) begin
                sh_mem[ea[11:0]] = ew;
                sh_v[ea[11:0]]   = 1'b1;
            end else begin
                sbq.push_back('{due: cyc + 2, id: id,
                                data: sh_v[ea[11:0]] ? sh_mem[ea[11:0]] : {v.sel, ea}});
            end
        end else begin
            e_mce = 1'b0; e_msel = 3'b100;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tests = 0; failed = 0; cyc = 0;
        for (int k = 0; k < 4096; k++) sh_v[k] = 1'b0;
        reset = 1'b1;
        bus.req = '0; bus.lock = '0; bus.req_sel = '0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mce", 32'(bus.mce), 32'd0);
        chk("rst_msel", 32'(bus.msel), 32'd4);
        chk("rst_maddr", 32'(bus.maddr), 32'd0);
        chk("rst_mdata_w", 32'(bus.mdata_w), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        e_mce = 1'b0; e_maddr = '0; e_msel = 3'b100; e_mdw = '0;

        // single read by requester 1 at address 5
        vecs.push_back(mk(0, 3'b010, 3'b000, 3'b010, 17'd4, 20'd0, 3'b010));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        // all three requesting from reset
        vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        for (int i = 0; i < 6; i++)
`ifdef RNN_ARB_QOS_EN
            vecs.push_back(mk(0, 3'b111, 3'b000, 3'b001, 17'h10, 20'd0, 3'b001));
`else
            vecs.push_back(mk(0, 3'b111, 3'b000, 3'b001, 17'h10, 20'd0, 3'(1 << (i % 3))));
`endif
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        // burst by requester 2 with requester 0 pending
        vecs.push_back(mk(0, 3'b100, 3'b100, 3'b011, 17'h200, 20'd0, 3'b100));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 3'b101, 3'b100, 3'b011, 17'h210 + 17'(i), 20'd0, 3'b100));
        vecs.push_back(mk(0, 3'b101, 3'b000, 3'b011, 17'h220, 20'd0, 3'b100));
        vecs.push_back(mk(0, 3'b101, 3'b000, 3'b011, 17'h230, 20'd0, 3'b001));
        vecs.push_back(mk(0, 3'b100, 3'b000, 3'b011, 17'h240, 20'd0, 3'b100));
        // burst abandoned by owner: nobody granted that cycle
        vecs.push_back(mk(0, 3'b010, 3'b010, 3'b000, 17'h300, 20'd0, 3'b010));
        vecs.push_back(mk(0, 3'b001, 3'b000, 3'b000, 17'h310, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b001, 3'b000, 3'b000, 17'h320, 20'd0, 3'b001));
        // write to result bank, then read back the same address
        vecs.push_back(mk(0, 3'b001, 3'b000, 3'b101, 17'h00A40, 20'h10000, 3'b001));
        vecs.push_back(mk(0, 3'b001, 3'b000, 3'b000, 17'h00A40, 20'd0, 3'b001));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        // reset the cycle after a read issue drops the response
        vecs.push_back(mk(0, 3'b010, 3'b000, 3'b110, 17'd6, 20'd0, 3'b010));
        vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        // priority behaviour with everyone requesting
        for (int i = 0; i < 4; i++)
`ifdef RNN_ARB_QOS_EN
            vecs.push_back(mk(0, 3'b111, 3'b000, 3'b010, 17'h400, 20'd0, 3'b001));
`else
            vecs.push_back(mk(0, 3'b111, 3'b000, 3'b010, 17'h400, 20'd0, 3'(1 << (i % 3))));
`endif
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 17'd0, 20'd0, 3'b000));

        foreach (vecs[i]) do_row(vecs[i]);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
